// File: rtl/core_bus_arbiter.sv
// rtl/core_bus_arbiter.sv - two-source (fetch/data) arbiter onto a single-outstanding memory port
module core_bus_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_req_valid,
  input  logic [ADDR_W-1:0]     i_req_addr,
  output logic                  i_req_ready,
  output logic                  i_resp_valid,
  output logic [31:0]           i_resp_inst,
  input  logic                  d_req_valid,
  input  logic [ADDR_W-1:0]     d_req_addr,
  input  logic                  d_req_we,
  input  logic [DATA_W-1:0]     d_req_wdata,
  input  logic [DATA_W/8-1:0]   d_req_wstrb,
  output logic                  d_req_ready,
  output logic                  d_resp_valid,
  output logic [DATA_W-1:0]     d_resp_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic                  mem_resp_valid,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t              state;
  logic                last_d;
  logic                src_d;
  logic                inst_hi;
  logic [31:0]         inst_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                grant_i;
  logic                grant_d;
  logic                resp_fire;
  logic [31:0]         inst_sel;
  logic                unused_addr_bits;

  // Fetches are word-aligned within the 64-bit beat; only bit 2 picks the half.
  assign unused_addr_bits = ^i_req_addr[1:0];

  // On a tie the source that did not win last time gets the grant.
  assign grant_i = (state == IDLE) && i_req_valid && (!d_req_valid || last_d);
  assign grant_d = (state == IDLE) && d_req_valid && !grant_i;

  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;

  assign resp_fire    = (state == WAIT) && mem_resp_valid;
  assign i_resp_valid = resp_fire && !src_d;
  assign d_resp_valid = resp_fire && src_d;

  assign inst_sel     = inst_hi ? mem_rdata[63:32] : mem_rdata[31:0];
  assign i_resp_inst  = i_resp_valid ? inst_sel : inst_q;
  assign d_resp_rdata = d_resp_valid ? mem_rdata : rdata_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      last_d        <= 1'b0;
      src_d         <= 1'b0;
      inst_hi       <= 1'b0;
      inst_q        <= '0;
      rdata_q       <= '0;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_we        <= 1'b0;
      mem_wdata     <= '0;
      mem_wstrb     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i) begin
            mem_addr      <= {i_req_addr[ADDR_W-1:3], 3'b000};
            mem_we        <= 1'b0;
            mem_wdata     <= '0;
            mem_wstrb     <= '0;
            inst_hi       <= i_req_addr[2];
            src_d         <= 1'b0;
            last_d        <= 1'b0;
            mem_req_valid <= 1'b1;
            state         <= ISSUE;
          end else if (grant_d) begin
            mem_addr      <= d_req_addr;
            mem_we        <= d_req_we;
            mem_wdata     <= d_req_wdata;
            mem_wstrb     <= d_req_wstrb;
            src_d         <= 1'b1;
            last_d        <= 1'b1;
            mem_req_valid <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            if (src_d) rdata_q <= mem_rdata;
            else       inst_q  <= inst_sel;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb/tb_core_bus_arbiter.sv - scoreboard bench for core_bus_arbiter
module tb_core_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_req_valid, i_req_ready, i_resp_valid;
  logic [63:0] i_req_addr;
  logic [31:0] i_resp_inst;
  logic        d_req_valid, d_req_we, d_req_ready, d_resp_valid;
  logic [63:0] d_req_addr, d_req_wdata, d_resp_rdata;
  logic [7:0]  d_req_wstrb;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_resp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wstrb;

  core_bus_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clock(clock), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_resp_valid(i_resp_valid), .i_resp_inst(i_resp_inst),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_we(d_req_we),
    .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb), .d_req_ready(d_req_ready),
    .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } mem_t;

  mem_t        mem_q[$];
  logic [31:0] i_q[$];
  logic [63:0] d_q[$];
  bit          d_chk_q[$];
  bit          grant_q[$];
  logic [63:0] rq[$];

  int tests = 0;
  int fails = 0;
  bit resp_en = 1'b1;
  int stall = 0;
  bit prev_grant = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant, handshake or response.
  always @(negedge clock) begin
    if (prev_grant) check("mem_req_valid_after_grant", mem_req_valid, 1'b1);
    if (i_req_ready || d_req_ready) begin
      check("ready_exclusive", i_req_ready && d_req_ready, 1'b0);
      if (grant_q.size() == 0) check("unexpected_grant", 1'b1, 1'b0);
      else check("grant_source", d_req_ready, grant_q.pop_front());
    end
    prev_grant = i_req_ready || d_req_ready;
    if (mem_req_valid && mem_req_ready) begin
      if (mem_q.size() == 0) check("unexpected_mem_req", 1'b1, 1'b0);
      else begin
        mem_t e;
        e = mem_q.pop_front();
        check("mem_addr", mem_addr, e.addr);
        check("mem_we", mem_we, e.we);
        check("mem_wdata", mem_wdata, e.wdata);
        check("mem_wstrb", mem_wstrb, e.wstrb);
      end
    end
    if (i_resp_valid) begin
      if (i_q.size() == 0) check("unexpected_i_resp", 1'b1, 1'b0);
      else check("i_resp_inst", i_resp_inst, i_q.pop_front());
    end
    if (d_resp_valid) begin
      if (d_q.size() == 0) check("unexpected_d_resp", 1'b1, 1'b0);
      else begin
        logic [63:0] ed;
        bit          ec;
        ed = d_q.pop_front();
        ec = d_chk_q.pop_front();
        if (ec) check("d_resp_rdata", d_resp_rdata, ed);
      end
    end
  end

  // Memory model: optional stall in ISSUE (fields must hold), then one response.
  initial begin
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
    forever begin
      tick();
      if (resp_en && mem_req_valid && !reset) begin
        mem_t cap;
        cap.addr = mem_addr; cap.we = mem_we; cap.wdata = mem_wdata; cap.wstrb = mem_wstrb;
        for (int s = 0; s < stall; s++) begin
          @(negedge clock);
          check("stall_valid", mem_req_valid, 1'b1);
          check("stall_addr", mem_addr, cap.addr);
          check("stall_wdata", mem_wdata, cap.wdata);
          check("stall_we_wstrb", {mem_we, mem_wstrb}, {cap.we, cap.wstrb});
          tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = (rq.size() != 0) ? rq.pop_front() : 64'h0;
        tick();
        mem_resp_valid = 1'b0;
      end
    end
  end

  task automatic push_i(input logic [63:0] addr, input logic [63:0] rdata, input logic [31:0] inst);
    mem_t m;
    m.addr = {addr[63:3], 3'b000}; m.we = 1'b0; m.wdata = '0; m.wstrb = '0;
    mem_q.push_back(m); rq.push_back(rdata); i_q.push_back(inst); grant_q.push_back(1'b0);
  endtask

  task automatic push_d(input logic [63:0] addr, input logic we, input logic [63:0] wdata,
                        input logic [7:0] wstrb, input logic [63:0] rdata);
    mem_t m;
    m.addr = addr; m.we = we; m.wdata = wdata; m.wstrb = wstrb;
    mem_q.push_back(m); rq.push_back(rdata); d_q.push_back(rdata); d_chk_q.push_back(!we);
    grant_q.push_back(1'b1);
  endtask

  task automatic run(input bit iv, input bit dv);
    int  cyc;
    bit  gi, gd;
    cyc = 0;
    i_req_valid = iv;
    d_req_valid = dv;
    while ((i_req_valid || d_req_valid) && cyc < 200) begin
      @(negedge clock);
      gi = i_req_ready; gd = d_req_ready;
      tick();
      if (gi) i_req_valid = 1'b0;
      if (gd) d_req_valid = 1'b0;
      cyc++;
    end
    check("grant_timeout", cyc >= 200, 1'b0);
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    cyc = 0;
    while ((i_q.size() != 0 || d_q.size() != 0 || mem_q.size() != 0) && cyc < 200) begin
      tick();
      cyc++;
    end
    check("drain_timeout", cyc >= 200, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    i_req_valid = 1'b0; i_req_addr = '0;
    d_req_valid = 1'b0; d_req_addr = '0; d_req_we = 1'b0; d_req_wdata = '0; d_req_wstrb = '0;
    repeat (2) @(negedge clock);
    check("rst_valids", {mem_req_valid, i_req_ready, d_req_ready, i_resp_valid, d_resp_valid}, 5'b0);
    check("rst_mem_addr", mem_addr, 64'h0);
    check("rst_mem_fields", {mem_we, mem_wstrb, mem_wdata}, 73'h0);
    check("rst_resp_data", {i_resp_inst, d_resp_rdata}, 96'h0);
    tick();
    reset = 1'b0;

    // Tie after reset: data first, then fetch; repeated tie alternates the same way.
    i_req_addr = 64'h100; d_req_addr = 64'h200; d_req_we = 1'b0;
    push_d(64'h200, 1'b0, 64'h0, 8'h00, 64'h5555_6666_7777_8888);
    push_i(64'h100, 64'hAAAA_BBBB_CCCC_DDDD, 32'hCCCC_DDDD);
    run(1'b1, 1'b1);
    i_req_addr = 64'h104; d_req_addr = 64'h208;
    push_d(64'h208, 1'b0, 64'h0, 8'h00, 64'h0102_0304_0506_0708);
    push_i(64'h104, 64'h7777_8888_9999_AAAA, 32'h7777_8888);
    run(1'b1, 1'b1);

    // Lone fetch, upper word, then hold check.
    i_req_addr = 64'h8000_0004;
    push_i(64'h8000_0004, 64'h1111_2222_3333_4444, 32'h1111_2222);
    run(1'b1, 1'b0);
    repeat (3) tick();
    @(negedge clock);
    check("i_inst_hold", i_resp_inst, 32'h1111_2222);

    // Lone fetch, lower word.
    tick();
    i_req_addr = 64'h8000_0008;
    push_i(64'h8000_0008, 64'h1111_2222_3333_4444, 32'h3333_4444);
    run(1'b1, 1'b0);

    // Data write.
    d_req_addr = 64'h1000; d_req_we = 1'b1; d_req_wdata = 64'hDEAD_BEEF_0000_0001; d_req_wstrb = 8'h0F;
    push_d(64'h1000, 1'b1, 64'hDEAD_BEEF_0000_0001, 8'h0F, 64'h0);
    run(1'b0, 1'b1);

    // Data read with 5-cycle stall in ISSUE; unaligned address passes through untouched.
    stall = 5;
    d_req_addr = 64'h2003; d_req_we = 1'b0; d_req_wdata = '0; d_req_wstrb = '0;
    push_d(64'h2003, 1'b0, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF);
    run(1'b0, 1'b1);
    stall = 0;

    // Spurious response in IDLE.
    resp_en = 1'b0;
    tick();
    mem_resp_valid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clock);
    check("spur_no_pulse", {i_resp_valid, d_resp_valid}, 2'b00);
    check("spur_d_hold", d_resp_rdata, 64'h0123_4567_89AB_CDEF);
    check("spur_i_hold", i_resp_inst, 32'h3333_4444);
    tick();
    mem_resp_valid = 1'b0;
    @(negedge clock);
    check("spur_idle", mem_req_valid, 1'b0);

    // Reset in WAIT aborts; a late response is ignored.
    tick();
    d_req_addr = 64'h3000; d_req_valid = 1'b1;
    begin
      mem_t m;
      m.addr = 64'h3000; m.we = 1'b0; m.wdata = '0; m.wstrb = '0;
      mem_q.push_back(m);
      grant_q.push_back(1'b1);
    end
    @(negedge clock);
    tick();
    d_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("abort_rst_outputs", {mem_req_valid, d_resp_valid, i_resp_valid}, 3'b000);
    check("abort_rst_rdata", d_resp_rdata, 64'h0);
    tick();
    reset = 1'b0;
    mem_resp_valid = 1'b1; mem_rdata = 64'hFFFF_0000_FFFF_0000;
    @(negedge clock);
    check("abort_late_resp", {i_resp_valid, d_resp_valid}, 2'b00);
    check("abort_mem_pending", mem_q.size(), 0);
    tick();
    mem_resp_valid = 1'b0;
    resp_en = 1'b1;
    d_req_addr = 64'h4000;
    push_d(64'h4000, 1'b0, 64'h0, 8'h00, 64'h0BAD_F00D_CAFE_0042);
    run(1'b0, 1'b1);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

endmodule
